// File: rtl/sys_array_nxn.sv
// sys_array_nxn: N x N output-stationary systolic matrix multiplier (C = A*B).
// A is fed one column and B one row per beat over a valid/ready stream. Lanes
// are skewed internally, and C is streamed out one row per accepted beat.
// Optional feature macro: SYS_ARRAY_SIGNED_EN selects two's-complement
// operands with sign-extended products. When it is undefined, operands are
// unsigned and products are zero-extended.
module sys_array_nxn #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 2*DW+$clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DW-1:0]         in_a,
  input  logic [N*DW-1:0]         in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*AW-1:0]         out_row,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    done
);

  localparam int IW  = $clog2(N);
  localparam int DCW = $clog2(2*N);
  localparam logic [IW-1:0]  BEAT_LAST  = IW'(N-1);
  localparam logic [IW-1:0]  ROW_LAST   = IW'(N-1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N-2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t              state_r;
  logic [IW-1:0]       beat_cnt_r;
  logic [DCW-1:0]      drain_cnt_r;
  logic                busy_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [N*AW-1:0]     out_row_r;
  logic [IW-1:0]       out_idx_r;
  logic                done_r;

  logic                xfer_s;
  logic                clr_s;
  logic [IW-1:0]       idx_next_s;

  logic [DW-1:0]       a_in_r   [N];
  logic [DW-1:0]       b_in_r   [N];
  logic [N-1:0][DW-1:0] a_edge_s;
  logic [N-1:0][DW-1:0] b_edge_s;
  logic [DW-1:0]       a_pipe_r [N][N-1];
  logic [DW-1:0]       b_pipe_r [N-1][N];
  logic [DW-1:0]       west_s   [N][N];
  logic [DW-1:0]       north_s  [N][N];
  logic [AW-1:0]       acc_r    [N][N];

  // Full-width product of one PE, extended to the accumulator width.
  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    logic [AW-1:0]   e;
`ifdef SYS_ARRAY_SIGNED_EN
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    e = {AW{p[2*DW-1]}};
`else
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    e = {AW{1'b0}};
`endif
    e[2*DW-1:0] = p;
    return e;
  endfunction

  assign xfer_s     = in_valid && in_ready_r;
  assign clr_s      = (state_r == ST_IDLE) && start;
  assign idx_next_s = out_idx_r + IW'(1);

  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_row   = out_row_r;
  assign out_idx   = out_idx_r;
  assign done      = done_r;

  // Capture an accepted beat; bubbles and non-LOAD cycles inject zeros.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      for (int i = 0; i < N; i++) begin
        a_in_r[i] <= '0;
        b_in_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_in_r[i] <= xfer_s ? in_a[i*DW +: DW] : {DW{1'b0}};
        b_in_r[i] <= xfer_s ? in_b[i*DW +: DW] : {DW{1'b0}};
      end
    end
  end

  // Lane l is delayed by l extra registers so the callers can feed unskewed data.
  for (genvar gl = 0; gl < N; gl++) begin : g_skew
    if (gl == 0) begin : g_direct
      assign a_edge_s[gl] = a_in_r[gl];
      assign b_edge_s[gl] = b_in_r[gl];
    end else begin : g_delay
      logic [DW-1:0] a_dly_r [gl];
      logic [DW-1:0] b_dly_r [gl];

      // Shift register of depth gl for the A and B lanes with index gl.
      always_ff @(posedge clk) begin
        if (rst || clr_s) begin
          for (int s = 0; s < gl; s++) begin
            a_dly_r[s] <= '0;
            b_dly_r[s] <= '0;
          end
        end else begin
          a_dly_r[0] <= a_in_r[gl];
          b_dly_r[0] <= b_in_r[gl];
          for (int s = 1; s < gl; s++) begin
            a_dly_r[s] <= a_dly_r[s-1];
            b_dly_r[s] <= b_dly_r[s-1];
          end
        end
      end

      assign a_edge_s[gl] = a_dly_r[gl-1];
      assign b_edge_s[gl] = b_dly_r[gl-1];
    end
  end

  // West/north operands of each PE come from the edge lanes or the neighbour's pipe.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        west_s[i][j]  = {DW{1'b0}};
        north_s[i][j] = {DW{1'b0}};
        if (j == 0) begin
          west_s[i][j] = a_edge_s[i];
        end else begin
          west_s[i][j] = a_pipe_r[i][(j == 0) ? 0 : j-1];
        end
        if (i == 0) begin
          north_s[i][j] = b_edge_s[j];
        end else begin
          north_s[i][j] = b_pipe_r[(i == 0) ? 0 : i-1][j];
        end
      end
    end
  end

  // PE grid: forward operands east/south and accumulate their product in place.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_r[i][j] <= '0;
        end
        for (int j = 0; j < N-1; j++) begin
          a_pipe_r[i][j] <= '0;
        end
      end
      for (int i = 0; i < N-1; i++) begin
        for (int j = 0; j < N; j++) begin
          b_pipe_r[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_r[i][j] <= acc_r[i][j] + mac_prod(west_s[i][j], north_s[i][j]);
        end
        for (int j = 0; j < N-1; j++) begin
          a_pipe_r[i][j] <= west_s[i][j];
        end
      end
      for (int i = 0; i < N-1; i++) begin
        for (int j = 0; j < N; j++) begin
          b_pipe_r[i][j] <= north_s[i][j];
        end
      end
    end
  end

  // Job sequencing (IDLE/LOAD/DRAIN/OUT) with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= '0;
      drain_cnt_r <= '0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_idx_r   <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_LOAD;
            busy_r      <= 1'b1;
            in_ready_r  <= 1'b1;
            beat_cnt_r  <= '0;
            drain_cnt_r <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            if (beat_cnt_r == BEAT_LAST) begin
              state_r     <= ST_DRAIN;
              in_ready_r  <= 1'b0;
              drain_cnt_r <= '0;
            end else begin
              beat_cnt_r <= beat_cnt_r + IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            // Row 0 finished accumulating long before the bottom-right PE.
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
            out_idx_r   <= '0;
            for (int j = 0; j < N; j++) begin
              out_row_r[j*AW +: AW] <= acc_r[0][j];
            end
          end else begin
            drain_cnt_r <= drain_cnt_r + DCW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (out_idx_r == ROW_LAST) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              out_valid_r <= 1'b0;
              out_idx_r   <= '0;
              out_row_r   <= '0;
              done_r      <= 1'b1;
            end else begin
              out_idx_r <= idx_next_s;
              for (int j = 0; j < N; j++) begin
                out_row_r[j*AW +: AW] <= acc_r[idx_next_s][j];
              end
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_idx_r   <= '0;
          out_row_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_nxn.sv
// tb_sys_array_nxn: directed + randomized bench for sys_array_nxn with an
// arithmetic matrix-product reference model.
module tb_sys_array_nxn;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2*DW+$clog2(N);
  localparam int IW = $clog2(N);
  localparam int VW = N*AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_a;
  logic [N*DW-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [N*AW-1:0]   out_row;
  logic [IW-1:0]     out_idx;
  logic              done;

  sys_array_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [AW-1:0] exp_c [N][N];
  logic [AW-1:0] obs_c [N][N];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] ext(input logic [DW-1:0] v);
`ifdef SYS_ARRAY_SIGNED_EN
    ext = {{(AW-DW){v[DW-1]}}, v};
`else
    ext = {{(AW-DW){1'b0}}, v};
`endif
  endfunction

  // C[i][j] = sum over k of A[i][k]*B[k][j], modulo 2^AW
  task automatic model();
    logic [AW-1:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + ext(ma[i][k]) * ext(mb[k][j]);
        exp_c[i][j] = s;
      end
  endtask

  function automatic logic [VW-1:0] exp_row(input int r);
    logic [VW-1:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = exp_c[r][j];
    return v;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_row"}, out_row, 0);
    chk({pfx, "_out_idx"}, out_idx, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // One job: bub_mode 0 none / 1 fixed 1,0,0,1,0,1,1 / 2 random; optional row stall,
  // a start poke during LOAD, and an abort by reset two cycles into DRAIN.
  task automatic run_job(input int bub_mode, input int stall_row, input int stall_n,
                         input bit poke_start, input bit abort);
    int t0, tl, nb, k, p, guard, extra, ns;
    logic v;
    bit [0:6] pat;
    pat = 7'b1001011;
    model();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0; p = 0; nb = 0; tl = 0;
    while (k < N && p < 4*N) begin
      chk("in_ready_load", in_ready, 1);
      start = (poke_start && p == 1) ? 1'b1 : 1'b0;
      case (bub_mode)
        1: v = (p < 7) ? pat[p] : 1'b1;
        2: v = ($urandom_range(0, 2) != 0) || (p >= 2*N);
        default: v = 1'b1;
      endcase
      in_valid = v;
      if (v) begin
        for (int i = 0; i < N; i++) begin
          in_a[i*DW +: DW] = ma[i][k];
          in_b[i*DW +: DW] = mb[k][i];
        end
        k++;
        if (k == N) tl = cyc + 1;
      end else begin
        in_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        nb++;
      end
      p++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("in_ready_drain", in_ready, 0);
    chk("busy_drain", busy, 1);
    if (abort) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check_reset_outputs("after_abort");
    end else begin
      guard = 0;
      while (!out_valid && guard < 8*N) begin
        @(negedge clk);
        guard++;
      end
      in_valid = 1'b0;
      chk("out_valid_rise_cycle", cyc, tl + 2*N - 1);
      extra = 0;
      for (int r = 0; r < N; r++) begin
        ns = (r == stall_row) ? stall_n : 0;
        for (int s = 0; s < ns; s++) begin
          out_ready = 1'b0;
          chk("stall_valid", out_valid, 1);
          chk("stall_idx", out_idx, r);
          chk("stall_row", out_row, exp_row(r));
          chk("stall_no_done", done, 0);
          extra++;
          @(negedge clk);
        end
        out_ready = 1'b1;
        chk("row_valid", out_valid, 1);
        chk("row_idx", out_idx, r);
        chk("row_data", out_row, exp_row(r));
        for (int j = 0; j < N; j++) obs_c[r][j] = out_row[j*AW +: AW];
        @(negedge clk);
      end
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_after_done", busy, 0);
      chk("out_valid_after_done", out_valid, 0);
      chk("latency", cyc - t0, 4*N + nb + extra);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic load_identity_ramp();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 32'd1 : 32'd0;
        mb[i][j] = DW'(N*i + j + 1);
      end
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom();
        mb[i][j] = $urandom();
      end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // identity times ramp, no bubbles: done 16 cycles after start
    load_identity_ramp();
    run_job(0, -1, 0, 1'b0, 1'b0);
    chk("ident_c00", obs_c[0][0], 1);
    chk("ident_c12", obs_c[1][2], 7);
    chk("ident_c33", obs_c[3][3], 16);

    // all-ones operands: widest unsigned sum
    load_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_job(0, -1, 0, 1'b0, 1'b0);
`ifndef SYS_ARRAY_SIGNED_EN
    chk("max_c32", obs_c[3][2], 66'h3_FFFF_FFF8_0000_0004);
`else
    chk("max_c32", obs_c[3][2], 66'd4);
`endif

    // bubble pattern 1,0,0,1,0,1,1
    load_identity_ramp();
    run_job(1, -1, 0, 1'b0, 1'b0);
    chk("bubble_c21", obs_c[2][1], 10);

    // back-pressure on row 2 for 3 cycles
    run_job(0, 2, 3, 1'b0, 1'b0);

    // abort two cycles into DRAIN, then a fresh job with a start poke during LOAD
    load_const(32'h7FFF_0001, 32'h0003_1234);
    run_job(0, -1, 0, 1'b1, 1'b1);
    load_random();
    run_job(2, 1, 2, 1'b1, 1'b0);

    // minus one times minus two
    load_const(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_job(0, -1, 0, 1'b0, 1'b0);
`ifdef SYS_ARRAY_SIGNED_EN
    chk("neg_c00", obs_c[0][0], 66'd8);
`else
    chk("neg_c00", obs_c[0][0], 66'h3_FFFF_FFF4_0000_0008);
`endif

    // randomized jobs with random bubbles and stalls
    for (int t = 0; t < 3; t++) begin
      load_random();
      run_job(2, $urandom_range(0, N-1), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sys_array_nxn.md
# sys_array_nxn

Parametrised N×N output-stationary systolic matrix multiplier that computes C = A·B for N×N operand matrices. It takes A one column and B one row per beat through a valid/ready stream, and skews the lanes internally so callers feed unskewed data. Once accumulation completes it streams C out row by row, then pulses `done`. It supersedes the fixed 4×4, externally skewed, free-running-counter array and sits between the operand buffer and the result writeback path.

## Interface
- `N`, 4: array dimension (rows = columns = beats per operand load); N ≥ 2.
- `DW`, 32: operand element width.
- `AW`, 2*DW+$clog2(N): accumulator and result element width; AW ≥ 2*DW.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new multiply; honoured only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  high only in LOAD.
- `in_a`  in  N*DW  column k of A; element row i at bits [i*DW +: DW].
- `in_b`  in  N*DW  row k of B; element column j at bits [j*DW +: DW].
- `out_valid`  out  1  result row valid.
- `out_ready`  in  1  result row accepted.
- `out_row`  out  N*AW  row r of C; element column j at bits [j*AW +: AW].
- `out_idx`  out  $clog2(N)  index r of the row presented on `out_row`.
- `done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
- The FSM has four states: IDLE, LOAD, DRAIN, OUT.
- IDLE → LOAD on `start`. In the same edge, all N² accumulators, all skew registers and all PE pass-through registers clear to 0, and the beat counter clears to 0.
- LOAD: a beat transfers when `in_valid && in_ready`. After the N-th transfer the FSM moves to DRAIN.
- Cycles with `in_valid` low inject zeros into every lane (a bubble). Bubbles are legal anywhere in LOAD and do not affect the result.
- Skew: A lane i passes through i registers before entering PE(i,0). B lane j passes through j registers before entering PE(0,j).
- Each PE registers its west input to its east output and its north input to its south output every cycle, and does `acc <= acc + west*north`.
- DRAIN lasts exactly 2N-1 cycles (counted by the drain counter), then the FSM moves to OUT with r = 0.
- OUT: `out_valid` = 1, `out_row` = acc row r, `out_idx` = r. On `out_ready`, r increments. Accepting row N-1 moves the FSM to IDLE and asserts `done` for that one cycle.
- Arithmetic: the product is full 2*DW width, extended to AW, and the accumulation wraps modulo 2^AW. The default is unsigned (zero-extend).
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored.
- `rst` (including mid-operation) returns the FSM to IDLE and zeroes all accumulators, skew/pipe registers and counters. An in-flight job is discarded.

## Timing
- Reset values: `busy` 0, `in_ready` 0, `out_valid` 0, `out_row` 0, `out_idx` 0, `done` 0.
- `start` sampled at edge T gives `in_ready` = 1 from T+1.
- The pair A[i][k], B[k][j] accepted at edge t_k meets in PE(i,j) at the input of edge t_k+i+j+1.
- The last product lands by edge t_last+2N-1. `out_valid` rises in the cycle after DRAIN ends.
- Unstalled job latency: 1 (start) + N (load) + 2N-1 (drain) + N (output) cycles from `start` to `done`.
- `out_row` and `out_idx` hold stable while `out_valid && !out_ready`.
- `done` is coincident with the IDLE transition. `start` in the cycle after `done` is accepted.

## Configuration
- `SYS_ARRAY_SIGNED_EN` defined: operands are two's-complement, and products are sign-extended to AW before accumulating.
- `SYS_ARRAY_SIGNED_EN` undefined: operands are unsigned and products are zero-extended.
- The macro changes nothing else: no port, timing or FSM difference.

## Test plan
- N=4, DW=32: A = identity, B[k][j] = 4k+j+1, no bubbles → rows {1,2,3,4}…{13,14,15,16}, `done` exactly 3N+N = 16 cycles after `start`.
- All A, B elements = 32'hFFFF_FFFF (unsigned) → every C element = 4·(2^32−1)^2 = 66'h3_FFFF_FFF8_0000_0004. Confirms no overflow at AW=66.
- Same operands as the first case with `in_valid` toggling 1,0,0,1,0,1,1 → identical C; `in_ready` stays high through LOAD.
- `out_ready` low for 3 cycles on row 2 → `out_row`/`out_idx`=2 stay stable; rows arrive in order 0..3 and `done` pulses once.
- `rst` asserted 2 cycles into DRAIN, then a new job → all outputs at reset values the following cycle; the new job's C has no residue from the aborted one. `start` pulsed during LOAD is ignored.
- With `SYS_ARRAY_SIGNED_EN`: A = all −1, B = all −2 → every C element = +8. Without the macro, same stimulus → 4·(2^32−1)(2^32−2) mod 2^66.
